program_loader: RTL
===================

// Module: program_loader
// PURPOSE
// Upstream loader for PROCESADOR_HARVARD program memory. It accepts instruction words
// ({opcode, 32-bit immediate}) over a valid/ready stream and buffers them in a small FIFO.
// It drives the processor's wr/address/data_in ports at sequential addresses from 0, then
// releases the processor into run mode (wr=0) after the last word. It replaces hand-driven
// load sequences in benches and feeds the processor from a host link in the top level.
// PARAMETERS
// OPCODE_W    5   width of the opcode field (matches opcode_e)
// DATA_W      32  width of the immediate field
// ADDR_W      7   program-memory address width; capacity 2**ADDR_W words
// FIFO_DEPTH  4   input buffer depth, power of 2, >=2
// HOLD_CYCLES 2   cycles each word is held on prog_address/prog_data, >=1
// (INSTR_W = OPCODE_W+DATA_W, derived localparam)
// PORTS
// clk          in   1        clock, rising edge
// reset        in   1        asynchronous, active-high reset
// load_start   in   1        1-cycle pulse: begin a new load from address 0
// s_valid      in   1        instruction word valid
// s_ready      out  1        loader can accept a word
// s_instr      in   INSTR_W  instruction word {opcode, immediate}
// s_last       in   1        qualifies s_instr as the final word of the program
// proc_reset   out  1        to processor reset
// prog_wr      out  1        to processor wr (1 = load mode, 0 = run)
// prog_address out  ADDR_W   to processor address
// prog_data    out  INSTR_W  to processor data_in
// done         out  1        program loaded, processor running
// err          out  1        overflow: more than 2**ADDR_W words offered
// words_loaded out  ADDR_W+1 count of words written in the current load
// BEHAVIOUR
// - Reset values: s_ready=0, proc_reset=1, prog_wr=0, prog_address=0, prog_data=0, done=0,
//   err=0, words_loaded=0; FIFO empty; state IDLE. Reset mid-load aborts immediately.
// - FSM states IDLE, LOAD, RUN, ERR:
//   IDLE: proc_reset=1, prog_wr=0, s_ready=0. On load_start -> LOAD.
//   LOAD: proc_reset=0, prog_wr=1. s_ready = FIFO not full AND last word not yet accepted.
//   RUN:  proc_reset=0, prog_wr=0, done=1, s_ready=0. On load_start -> LOAD.
//   ERR:  proc_reset=1, prog_wr=0, err=1, s_ready=0. On load_start -> LOAD; otherwise held until reset.
// - Entering LOAD from any state in the same cycle: flush FIFO, address counter=0,
//   words_loaded=0, done=0, err=0, hold counter=0. Ignore load_start while in LOAD.
// - A transfer occurs on a clk edge with s_valid & s_ready. A word carrying s_last sets a
//   last_seen flag, and s_ready drops the next cycle.
// - Write sequencing:
//   - When the bus is idle or hold has expired and the FIFO is non-empty, pop one word.
//   - On that edge, register prog_address<=addr_cnt, prog_data<=word, increment addr_cnt
//     and words_loaded, and restart the hold counter.
//   - Each word is held stable for exactly HOLD_CYCLES cycles. prog_wr stays high across
//     words, and the processor rewriting the same word is harmless.
// - Latency: a word accepted at edge t into an empty FIFO, with the bus free, appears on
//   prog_* after edge t+1.
// - Transition to RUN occurs on the edge where the last word's hold expires. prog_wr
//   falls that edge, and prog_address/prog_data keep their last values.
// - Overflow: a word popped when words_loaded == 2**ADDR_W is not written -> ERR.
//   Writing address 2**ADDR_W-1 with s_last set is legal -> RUN.
// - A simultaneous push and pop on a full FIFO is not possible: s_ready is low when full.
//   A push and pop in the same cycle on a non-full FIFO are both honoured.
// - s_valid while s_ready=0 is ignored. The source holds its word until it is accepted.
// TESTING
// 1. Reset, load_start, stream 3 words 0x01_00000005, 0x02_00000003, 0x03_00000001 (last)
//    -> prog_address 0,1,2, each held 2 cycles; then prog_wr=0, done=1, words_loaded=3.
// 2. Back-to-back s_valid with HOLD_CYCLES=2, FIFO_DEPTH=4
//    -> s_ready drops after 4 buffered words, no word lost or reordered.
// 3. s_valid before load_start (IDLE) -> s_ready=0, no prog_wr, proc_reset stays 1.
// 4. ADDR_W=3: 8 words with last on the 8th -> RUN; 9 words with no last -> err=1,
//    proc_reset=1, address 7 data unchanged.
// 5. Async reset asserted mid-load after 2 words
//    -> all outputs to reset values within the same cycle; a new load_start restarts at address 0.
// 6. load_start in RUN -> done=0, prog_wr=1, next word written at address 0.

Source files
------------

// File: rtl/program_loader.sv
// Streams instruction words from a valid/ready source into the processor's program memory
// at sequential addresses, then releases the processor into run mode.
module program_loader #(
  parameter int OPCODE_W    = 5,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [OPCODE_W+DATA_W-1:0]   s_instr,
  input  logic                         s_last,
  output logic                         proc_reset,
  output logic                         prog_wr,
  output logic [ADDR_W-1:0]            prog_address,
  output logic [OPCODE_W+DATA_W-1:0]   prog_data,
  output logic                         done,
  output logic                         err,
  output logic [ADDR_W:0]              words_loaded
);

  localparam int INSTR_W = OPCODE_W + DATA_W;
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W:0]  CAPACITY  = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [PW:0]      FIFO_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

  state_t state, state_nxt;

  logic [INSTR_W:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count;
  logic                last_seen;
  logic                bus_busy;
  logic                bus_last;
  logic [HW-1:0]       hold_cnt;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [INSTR_W:0]    head;

  logic start, in_load, full, empty, hold_done, bus_free;
  logic push, pop, overflow, write, finish;

  assign start     = load_start && (state != LOAD);
  assign in_load   = (state == LOAD);
  assign full      = (count == FIFO_FULL);
  assign empty     = (count == '0);
  assign hold_done = bus_busy && (hold_cnt == HOLD_LAST);
  assign bus_free  = !bus_busy || hold_done;
  assign s_ready   = in_load && !full && !last_seen;
  assign push      = s_valid && s_ready;
  assign pop       = in_load && bus_free && !empty;
  assign overflow  = pop && (words_loaded == CAPACITY);
  assign write     = pop && !overflow;
  // The last word leaves the FIFO before its hold ends, so empty confirms nothing follows it.
  assign finish    = in_load && hold_done && bus_last && empty;
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    proc_reset = 1'b1;
    prog_wr    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_nxt = LOAD;
      end
      LOAD: begin
        proc_reset = 1'b0;
        prog_wr    = 1'b1;
        if (overflow)    state_nxt = ERR;
        else if (finish) state_nxt = RUN;
      end
      RUN: begin
        proc_reset = 1'b0;
        done       = 1'b1;
        if (load_start) state_nxt = LOAD;
      end
      ERR: begin
        err = 1'b1;
        if (load_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {s_last, s_instr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_seen    <= 1'b0;
      bus_busy     <= 1'b0;
      bus_last     <= 1'b0;
      hold_cnt     <= '0;
      addr_cnt     <= '0;
      words_loaded <= '0;
      prog_address <= '0;
      prog_data    <= '0;
    end else if (start) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_seen    <= 1'b0;
      bus_busy     <= 1'b0;
      bus_last     <= 1'b0;
      hold_cnt     <= '0;
      addr_cnt     <= '0;
      words_loaded <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (s_last) last_seen <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (write) begin
        prog_address <= addr_cnt;
        prog_data    <= head[INSTR_W-1:0];
        bus_last     <= head[INSTR_W];
        addr_cnt     <= addr_cnt + 1'b1;
        words_loaded <= words_loaded + 1'b1;
        hold_cnt     <= '0;
        bus_busy     <= 1'b1;
      end else if (hold_done) begin
        bus_busy <= 1'b0;
      end else if (bus_busy) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
